// File: rtl/lite16_alu_pkg.sv
// lite16_alu_pkg: opcode and form-select constants plus the data word type for the LITE-16 ALU
package lite16_alu_pkg;
    typedef logic [15:0] word_t;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;
    localparam logic RI_REG = 1'b0;
    localparam logic RI_IMM = 1'b1;
endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: combinational 16-bit barrel shifter, zero fill
//   d    : input word
//   left : 1 = shift left, 0 = logical shift right
//   amt  : shift amount 0..15
//   q    : shifted word
module alu_shifter
    import lite16_alu_pkg::*;
(
    input  word_t      d,
    input  logic       left,
    input  logic [3:0] amt,
    output word_t      q
);
    assign q = left ? d << amt : d >> amt;
endmodule

// File: rtl/alu.sv
// alu: 16-bit registered ALU, one-cycle latency
//   clk, rst_n : clock, asynchronous active-low reset
//   codeop     : operation select
//   a, rd      : first operand candidates (a when ri=0, rd when ri=1)
//   b          : second operand (immediate already extended when ri=1)
//   ri         : form select
//   r, cmp     : registered result and equality flag
module alu
    import lite16_alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] codeop,
    input  word_t      a,
    input  word_t      b,
    input  word_t      rd,
    input  logic       ri,
    output word_t      r,
    output logic       cmp
);
    word_t x;
    word_t sh;
    word_t res;
    assign x = (ri == RI_IMM) ? rd : a;
    // only b[3:0] reaches the shifter, so the upper amount bits are ignored
    alu_shifter u_shifter (
        .d    (x),
        .left (codeop == OP_SLL),
        .amt  (b[3:0]),
        .q    (sh)
    );
    always_comb begin
        res = '0;
        case (codeop)
            OP_ADD:  res = x + b;
            OP_SUB:  res = x - b;
            OP_AND:  res = x & b;
            OP_OR:   res = x | b;
            OP_XOR:  res = x ^ b;
            OP_SLL:  res = sh;
            OP_SRL:  res = sh;
            default: res = {15'd0, $signed(x) < $signed(b)};
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r   <= '0;
            cmp <= 1'b0;
        end else begin
            r   <= res;
            cmp <= (x == b);
        end
    end
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed self-checking bench for alu
module tb_alu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  codeop = 3'd0;
    logic [15:0] a = 16'h0007;
    logic [15:0] b = 16'h0006;
    logic [15:0] rd = 16'h0005;
    logic        ri = 1'b0;
    logic [15:0] r;
    logic        cmp;
    int          n_cmp = 0;
    int          n_bad = 0;

    alu dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .codeop (codeop),
        .a      (a),
        .b      (b),
        .rd     (rd),
        .ri     (ri),
        .r      (r),
        .cmp    (cmp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic op(input string tag, input logic f, input logic [2:0] c,
                      input logic [15:0] va, input logic [15:0] vb, input logic [15:0] vrd,
                      input logic [15:0] er, input logic ec);
        @(negedge clk);
        ri = f; codeop = c; a = va; b = vb; rd = vrd;
        @(posedge clk);
        #1;
        check({tag, ".r"}, r, er);
        check({tag, ".cmp"}, {15'd0, cmp}, {15'd0, ec});
    endtask

    logic [15:0] exp_reg [8] = '{16'h000D, 16'h0001, 16'h0006, 16'h0007,
                                  16'h0001, 16'h01C0, 16'h0000, 16'h0000};
    logic [15:0] exp_imm [8] = '{16'h000B, 16'hFFFF, 16'h0004, 16'h0007,
                                  16'h0003, 16'h0140, 16'h0000, 16'h0001};

    initial begin
        // reset held from time 0 while the clock runs
        repeat (2) @(posedge clk);
        #1;
        check("rst0.r", r, 16'h0000);
        check("rst0.cmp", {15'd0, cmp}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        op("rel_add", 1'b0, 3'd0, 16'h0007, 16'h0006, 16'h0005, 16'h000D, 1'b0);
        // asynchronous reset mid-cycle clears outputs without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid.r", r, 16'h0000);
        check("rst_mid.cmp", {15'd0, cmp}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        op("post_rst", 1'b0, 3'd0, 16'h0007, 16'h0006, 16'h0005, 16'h000D, 1'b0);

        for (int i = 0; i < 8; i++)
            op($sformatf("reg%0d", i), 1'b0, 3'(i), 16'h0007, 16'h0006, 16'h0005, exp_reg[i], 1'b0);
        for (int i = 0; i < 8; i++)
            op($sformatf("imm%0d", i), 1'b1, 3'(i), 16'h0007, 16'h0006, 16'h0005, exp_imm[i], 1'b0);

        op("eq_sub",   1'b0, 3'd1, 16'h1234, 16'h1234, 16'h0005, 16'h0000, 1'b1);
        op("eq_imm",   1'b1, 3'd2, 16'h0000, 16'hA5A5, 16'hA5A5, 16'hA5A5, 1'b1);
        op("slt_sgn",  1'b0, 3'd7, 16'h8000, 16'h0001, 16'h0005, 16'h0001, 1'b0);
        op("slt_pos",  1'b0, 3'd7, 16'h0001, 16'h8000, 16'h0005, 16'h0000, 1'b0);
        op("add_wrap", 1'b0, 3'd0, 16'hFFFF, 16'h0001, 16'h0005, 16'h0000, 1'b0);
        op("sll_mask", 1'b0, 3'd5, 16'h0001, 16'h0011, 16'h0005, 16'h0002, 1'b0);
        op("srl_mask", 1'b0, 3'd6, 16'h8000, 16'h00FF, 16'h0005, 16'h0001, 1'b0);
        op("sll_15",   1'b1, 3'd5, 16'h0000, 16'h000F, 16'h0003, 16'h8000, 1'b0);

        // back-to-back with ri and codeop changing together every cycle
        op("b2b0", 1'b0, 3'd1, 16'h0010, 16'h0003, 16'h0100, 16'h000D, 1'b0);
        op("b2b1", 1'b1, 3'd0, 16'h0010, 16'h0003, 16'h0100, 16'h0103, 1'b0);
        op("b2b2", 1'b0, 3'd4, 16'h00F0, 16'h0F0F, 16'hFFFF, 16'h0FFF, 1'b0);
        op("b2b3", 1'b1, 3'd6, 16'h00F0, 16'h0004, 16'hF000, 16'h0F00, 1'b0);
        op("b2b4", 1'b0, 3'd3, 16'h0003, 16'h0003, 16'h1111, 16'h0003, 1'b1);
        op("b2b5", 1'b1, 3'd7, 16'h0000, 16'hFFFE, 16'hFFFF, 16'h0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
